// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, drives the combinational-read imem and
// registers the returned word into the fetch stage with stall, redirect, halt and fault.
module imem_fetch_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'd0,
   parameter int unsigned MEM_DEPTH = 11,
   parameter logic [31:0] EXIT_WORD = 32'hFFFF_FFFF
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        Start,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] RedirectAddr,
   output logic [31:0] Addr,
   input  logic [31:0] InstrIn,
   output logic [31:0] InstrOut,
   output logic [31:0] InstrPC,
   output logic        InstrValid,
   output logic        Halted,
   output logic        Fault
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_FAULT} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] ipc_q, ipc_d;
   logic        vld_q, vld_d;
   logic        pc_oob;

   assign pc_oob = (pc_q >= 32'(MEM_DEPTH));

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         ipc_q   <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         vld_q   <= vld_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      vld_d   = vld_q;
      case (state_q)
         S_RUN: begin
            // Redirect squashes the in-flight word even when decode is stalled.
            if (Redirect) begin
               pc_d  = RedirectAddr;
               vld_d = 1'b0;
            end else if (Stall) begin
               pc_d = pc_q;
            end else if (pc_oob) begin
               state_d = S_FAULT;
               vld_d   = 1'b0;
            end else begin
               instr_d = InstrIn;
               ipc_d   = pc_q;
               vld_d   = 1'b1;
               if (InstrIn == EXIT_WORD) state_d = S_HALT;
               else                      pc_d    = pc_q + 32'd1;
            end
         end
         default: begin
            if (Start) begin
               state_d = S_RUN;
               pc_d    = RESET_PC;
               vld_d   = 1'b0;
            end else if (state_q == S_HALT && !Stall) begin
               // The exit word is presented to decode exactly once.
               vld_d = 1'b0;
            end
         end
      endcase
   end

   assign Addr       = pc_q;
   assign InstrOut   = instr_q;
   assign InstrPC    = ipc_q;
   assign InstrValid = vld_q;
   assign Halted     = (state_q == S_HALT);
   assign Fault      = (state_q == S_FAULT);

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Bench for imem_fetch_sequencer: directed walk through fetch, stall, redirect, halt,
// fault and reset, then random traffic, all against a behavioural fetch model.
module tb_imem_fetch_sequencer;

   localparam logic [31:0] EXITW = 32'hFFFF_FFFF;
   localparam int unsigned DEPTH = 11;

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic        Start = 1'b0, Stall = 1'b0, Redirect = 1'b0;
   logic [31:0] RedirectAddr = '0;
   logic [31:0] Addr, InstrIn, InstrOut, InstrPC;
   logic        InstrValid, Halted, Fault;

   logic [31:0] mem [0:15];

   int total = 0;
   int bad   = 0;

   // model of the architectural state
   bit          m_run, m_halt, m_flt, m_vld;
   logic [31:0] m_pc, m_out, m_ipc;

   always #5 Clk = ~Clk;

   assign InstrIn = (Addr < 32'(DEPTH)) ? mem[Addr[3:0]] : 32'h0BAD_0BAD;

   imem_fetch_sequencer #(.RESET_PC(32'd0), .MEM_DEPTH(DEPTH), .EXIT_WORD(EXITW)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Stall(Stall), .Redirect(Redirect),
      .RedirectAddr(RedirectAddr), .Addr(Addr), .InstrIn(InstrIn), .InstrOut(InstrOut),
      .InstrPC(InstrPC), .InstrValid(InstrValid), .Halted(Halted), .Fault(Fault));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_halt = 0; m_flt = 0; m_vld = 0;
      m_pc = 32'd0; m_out = '0; m_ipc = '0;
   endtask

   // One clock edge of the fetch rules, computed from the pre-edge state and inputs.
   task automatic model_step(input bit st, input bit sl, input bit rd, input logic [31:0] ra);
      logic [31:0] word;
      word = (m_pc < 32'(DEPTH)) ? mem[m_pc[3:0]] : 32'h0BAD_0BAD;
      if (!m_run) begin
         if (st) begin
            m_run = 1; m_halt = 0; m_flt = 0; m_pc = 32'd0; m_vld = 0;
         end else if (m_halt && !sl) m_vld = 0;
      end else if (rd) begin
         m_pc = ra; m_vld = 0;
      end else if (!sl) begin
         if (m_pc >= 32'(DEPTH)) begin
            m_run = 0; m_flt = 1; m_vld = 0;
         end else begin
            m_out = word; m_ipc = m_pc; m_vld = 1;
            if (word == EXITW) begin m_run = 0; m_halt = 1; end
            else m_pc = m_pc + 1;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".Addr"},  Addr, m_pc);
      chk({tag, ".Vld"},   {31'd0, InstrValid}, {31'd0, m_vld});
      chk({tag, ".Halt"},  {31'd0, Halted}, {31'd0, m_halt});
      chk({tag, ".Fault"}, {31'd0, Fault}, {31'd0, m_flt});
      chk({tag, ".Out"},   InstrOut, m_out);
      chk({tag, ".IPC"},   InstrPC, m_ipc);
   endtask

   task automatic cycle(input bit st, input bit sl, input bit rd, input logic [31:0] ra);
      Start = st; Stall = sl; Redirect = rd; RedirectAddr = ra;
      model_step(st, sl, rd, ra);
      @(posedge Clk);
      #1;
      check_all("cyc");
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i * 17);
      mem[5] = EXITW;
      model_reset();
      #2;
      check_all("reset");
      chk("reset.IPC0", InstrPC, 32'd0);
      @(negedge Clk) Rst_n = 1'b1;

      // straight-line program ending at the exit word
      cycle(1, 0, 0, 0);
      idle_n(6);
      chk("p1.ipc5", InstrPC, 32'd5);
      chk("p1.halt", {31'd0, Halted}, 32'd1);
      chk("p1.addr5", Addr, 32'd5);
      idle_n(1);
      chk("p1.vldclr", {31'd0, InstrValid}, 32'd0);

      // stall while halted keeps the exit word visible
      cycle(1, 0, 0, 0);
      idle_n(6);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 0, 0);
         chk("p6.haltvld", {31'd0, InstrValid}, 32'd1);
      end
      idle_n(1);
      chk("p6.vldclr", {31'd0, InstrValid}, 32'd0);

      // jumps: squash, land on 6,7 then back to 4,5 and halt
      cycle(1, 0, 0, 0);
      idle_n(4);
      chk("p2.ipc3", InstrPC, 32'd3);
      cycle(0, 0, 1, 32'd6);
      chk("p2.squash", {31'd0, InstrValid}, 32'd0);
      idle_n(1);
      chk("p2.ipc6", InstrPC, 32'd6);
      idle_n(1);
      chk("p2.ipc7", InstrPC, 32'd7);
      cycle(0, 0, 1, 32'd4);
      idle_n(1);
      chk("p2.ipc4", InstrPC, 32'd4);
      idle_n(1);
      chk("p2.halt", {31'd0, Halted}, 32'd1);

      // stall hold, then stall+redirect
      cycle(1, 0, 0, 0);
      idle_n(2);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 0, 0);
         chk("p3.ipc1", InstrPC, 32'd1);
         chk("p3.addr2", Addr, 32'd2);
      end
      idle_n(1);
      chk("p3.ipc2", InstrPC, 32'd2);
      cycle(0, 1, 1, 32'd6);
      idle_n(1);
      chk("p3.ipc6", InstrPC, 32'd6);

      // out-of-range target faults on the next unstalled fetch
      cycle(0, 0, 1, 32'd11);
      idle_n(1);
      chk("p4.fault", {31'd0, Fault}, 32'd1);
      chk("p4.addr11", Addr, 32'd11);
      cycle(1, 0, 0, 0);
      chk("p4.fclr", {31'd0, Fault}, 32'd0);
      idle_n(1);
      chk("p4.ipc0", InstrPC, 32'd0);

      // Start while running has no effect
      idle_n(1);
      cycle(1, 0, 0, 0);
      chk("p6.ipc2", InstrPC, 32'd2);

      // asynchronous reset mid-run at PC=4
      idle_n(1);
      chk("p5.addr4", Addr, 32'd4);
      #2 Rst_n = 1'b0;
      #1;
      model_reset();
      check_all("p5.async");
      @(negedge Clk) Rst_n = 1'b1;
      cycle(1, 0, 0, 0);
      idle_n(1);
      chk("p5.ipc0", InstrPC, 32'd0);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         bit st, sl, rd;
         st = ($urandom_range(0, 19) == 0);
         sl = ($urandom_range(0, 9) < 3);
         rd = ($urandom_range(0, 9) == 0);
         cycle(st, sl, rd, 32'($urandom_range(0, 12)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_fetch_sequencer.md
Name: imem_fetch_sequencer

Overview:
- Sequences the word-addressed, combinational-read instruction memory: owns the PC, drives the memory address and registers the returned word into a fetch stage for decode.
- Handles decode stall, jump/JAL/JR redirect, exit-word halt and out-of-range fault.
- Sits between the instruction memory and the decode/control unit.

Parameters:
- RESET_PC, 0, word address of the first instruction fetched after Start.
- MEM_DEPTH, 11, number of valid instruction words; a fetch address >= MEM_DEPTH is a fault.
- EXIT_WORD, 32'hFFFFFFFF, instruction encoding that ends the program.

Ports:
- Clk  in  1  system clock, rising-edge.
- Rst_n  in  1  asynchronous active-low reset.
- Start  in  1  begin (or restart) execution at RESET_PC; a level sampled on the clock edge.
- Stall  in  1  decode cannot accept; hold the fetch stage and PC.
- Redirect  in  1  taken jump/JAL/JR this cycle.
- RedirectAddr  in  32  word address of the redirect target.
- Addr  out  32  instruction memory address, equal to the PC register.
- InstrIn  in  32  word returned combinationally by memory for Addr.
- InstrOut  out  32  registered instruction presented to decode.
- InstrPC  out  32  address InstrOut was fetched from.
- InstrValid  out  1  InstrOut/InstrPC are valid.
- Halted  out  1  exit word reached.
- Fault  out  1  fetch from an address >= MEM_DEPTH.

Behaviour:
- Reset (async, Rst_n=0):
  - State = IDLE, PC = RESET_PC.
  - InstrOut, InstrPC, InstrValid, Halted and Fault = 0.
- States and entry conditions:
  - IDLE: nothing latched. Start=1 -> RUN with PC = RESET_PC and InstrValid = 0.
  - RUN: per-edge priority is Redirect > Stall > fault check > normal fetch.
  - HALT: Halted = 1, PC frozen, Redirect ignored. InstrValid clears on the first edge with Stall = 0, so the exit word is consumed exactly once. Start=1 -> RUN as from IDLE and clears Halted.
  - FAULT: Fault = 1, InstrValid = 0, PC frozen at the offending address. Start=1 -> RUN and clears Fault.
- RUN, Redirect=1 (overrides Stall):
  - PC <= RedirectAddr; InstrValid <= 0 (squashes the wrong-path word).
  - Redirect-to-first-fetched-word latency is 2 edges.
- RUN, Stall=1 and Redirect=0:
  - PC, InstrOut, InstrPC and InstrValid all hold.
- RUN, no Stall and no Redirect, PC >= MEM_DEPTH:
  - -> FAULT; InstrValid <= 0; no latch.
- RUN, normal fetch:
  - InstrOut <= InstrIn, InstrPC <= PC, InstrValid <= 1.
  - If InstrIn == EXIT_WORD: -> HALT with PC unchanged. Otherwise PC <= PC + 1.
  - Fetch latency is 1 edge; one instruction per cycle when unstalled.
- Arithmetic: PC increment is 32-bit modulo 2^32; wrap is never reached because MEM_DEPTH faults first.
- Start while in RUN is ignored.
- Redirect and Stall are ignored outside RUN.
- An out-of-range redirect target is accepted; the fault is raised on the next unstalled fetch.
- Reset mid-operation aborts immediately to the reset values above. No partial state survives.

Test Plan:
1. Reset, Start pulse, memory preloaded with the 8-word program (exit word at address 5), no stall or redirect -> InstrPC sequence 0,1,2,3,4,5 on consecutive cycles with InstrValid = 1; Halted = 1 the edge address 5 is latched; Addr stays 5; InstrValid clears the next edge.
2. At InstrPC = 3 (JAL), assert Redirect with RedirectAddr = 6 for 1 cycle -> the word in flight is squashed (InstrValid 0 for one cycle), next valid InstrPC = 6, then 7. Then Redirect to 4 -> InstrPC 4, then 5 (exit), then Halted.
3. Stall held for 3 cycles while InstrPC = 1 -> InstrOut, InstrPC = 1 and InstrValid = 1 are unchanged and Addr stays 2; after release InstrPC = 2 on the next edge. Stall and Redirect(6) in the same cycle -> redirect wins, next valid InstrPC = 6.
4. Redirect to 11 with MEM_DEPTH = 11 -> next unstalled edge Fault = 1, InstrValid = 0, Addr = 11. Start -> Fault = 0, PC = 0, fetch resumes at 0.
5. Drop Rst_n asynchronously mid-RUN at PC = 4 -> all outputs are 0 immediately without a clock edge, Addr = RESET_PC. Start after release -> InstrPC 0 first.
6. While HALT with Stall = 1 -> InstrValid stays 1 (exit word held) until Stall drops. Start while in RUN at PC = 2 -> no effect, next InstrPC = 2.
